// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCC,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [1:0]        DBG_STATE
);

  // Handshake: a transfer happens on a side only when its valid and ready are
  // both 1 at the rising edge; the sender holds its payload stable until then.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam bit USE_SKID = (SKID != 0);

  state_t            state;
  state_t            state_nxt;
  logic              valid_q;
  logic [1:0]        occ_q;
  logic              ready_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  // ready_q is 0 through reset and tracks "next state is not FULL" afterwards,
  // which makes IN_READY a register output in skid mode.
  always_comb begin
    if (USE_SKID) IN_READY = ready_q & ~FLUSH;
    else          IN_READY = ready_q & (~valid_q | OUT_READY) & ~FLUSH;
  end

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = valid_q & OUT_READY;

  always_comb begin
    state_nxt = state;
    if (FLUSH) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_nxt = HALF;
        HALF: begin
          if (in_fire && !out_fire && USE_SKID) state_nxt = FULL;
          else if (!in_fire && out_fire)        state_nxt = EMPTY;
        end
        FULL:    if (out_fire) state_nxt = HALF;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= EMPTY;
      valid_q   <= 1'b0;
      occ_q     <= 2'd0;
      ready_q   <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt != EMPTY);
      ready_q <= (state_nxt != FULL);
      case (state_nxt)
        HALF:    occ_q <= 2'd1;
        FULL:    occ_q <= 2'd2;
        default: occ_q <= 2'd0;
      endcase
      // Payload registers are held on flush; only validity is dropped.
      if (!FLUSH) begin
        if (state == FULL && out_fire) begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end else if (in_fire && (state == EMPTY || out_fire)) begin
          main_ctrl <= IN_CTRL;
          main_data <= IN_DATA;
        end else if (in_fire) begin
          skid_ctrl <= IN_CTRL;
          skid_data <= IN_DATA;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      STALL_CNT <= '0;
    end else if (valid_q && !OUT_READY && !(&STALL_CNT)) begin
      STALL_CNT <= STALL_CNT + 1'b1;
    end
  end

  assign OUT_VALID = valid_q;
  assign OUT_CTRL  = main_ctrl & {CTRL_W{valid_q}};
  assign OUT_DATA  = main_data;
  assign OCC       = occ_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (CNT_W=4) and a single-entry
// instance run side by side against a queue-based reference model.
module tb_pipe_stage_skid;

  logic        CLK;
  logic        RESET;

  logic        iv[2];
  logic [7:0]  ic[2];
  logic [31:0] idat[2];
  logic        ordy[2];
  logic        fl[2];

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [7:0]  a_out_ctrl, b_out_ctrl;
  logic [31:0] a_out_data, b_out_data;
  logic [1:0]  a_occ, b_occ, a_state, b_state;
  logic [3:0]  a_stall;
  logic [15:0] b_stall;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .FLUSH(fl[0]),
    .IN_VALID(iv[0]), .IN_READY(a_in_ready), .IN_CTRL(ic[0]), .IN_DATA(idat[0]),
    .OUT_VALID(a_out_valid), .OUT_READY(ordy[0]), .OUT_CTRL(a_out_ctrl),
    .OUT_DATA(a_out_data), .OCC(a_occ), .STALL_CNT(a_stall), .DBG_STATE(a_state)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut_b (
    .CLK(CLK), .RESET(RESET), .FLUSH(fl[1]),
    .IN_VALID(iv[1]), .IN_READY(b_in_ready), .IN_CTRL(ic[1]), .IN_DATA(idat[1]),
    .OUT_VALID(b_out_valid), .OUT_READY(ordy[1]), .OUT_CTRL(b_out_ctrl),
    .OUT_DATA(b_out_data), .OCC(b_occ), .STALL_CNT(b_stall), .DBG_STATE(b_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: each stage is a FIFO of {ctrl,data} with capacity 2 or 1
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];
  int          exp_cnt[2];
  int          cnt_max[2];
  bit          alive[2];
  int          tests;
  int          fails;

  function automatic int qsize(input int u);
    if (u == 0) return exp_q0.size();
    return exp_q1.size();
  endfunction

  function automatic logic [39:0] qhead(input int u);
    if (u == 0) return exp_q0[0];
    return exp_q1[0];
  endfunction

  function automatic void qpush(input int u, input logic [39:0] e);
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  function automatic void qpop(input int u);
    if (u == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endfunction

  function automatic void model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int u = 0; u < 2; u++) begin
      exp_cnt[u] = 0;
      alive[u]   = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: inputs are set at the falling edge, outputs compared 1ns later
  task automatic step();
    logic        oir[2], ov[2];
    logic [7:0]  oc[2];
    logic [31:0] od[2];
    logic [1:0]  oo[2];
    logic [15:0] os[2];
    bit          er[2], fin[2], fout[2];
    int          sz;
    #1;
    oir[0] = a_in_ready;  oir[1] = b_in_ready;
    ov[0]  = a_out_valid; ov[1]  = b_out_valid;
    oc[0]  = a_out_ctrl;  oc[1]  = b_out_ctrl;
    od[0]  = a_out_data;  od[1]  = b_out_data;
    oo[0]  = a_occ;       oo[1]  = b_occ;
    os[0]  = {12'd0, a_stall}; os[1] = b_stall;
    for (int u = 0; u < 2; u++) begin
      sz    = qsize(u);
      er[u] = alive[u] && !fl[u] && ((u == 0) ? (sz < 2) : (sz == 0 || ordy[u]));
      chk($sformatf("u%0d in_ready", u), oir[u], er[u]);
      chk($sformatf("u%0d out_valid", u), ov[u], sz > 0);
      chk($sformatf("u%0d out_ctrl", u), oc[u], (sz > 0) ? qhead(u) >> 32 : 40'd0);
      if (sz > 0) chk($sformatf("u%0d out_data", u), od[u], qhead(u) & 40'hFF_FFFF_FFFF >> 8);
      chk($sformatf("u%0d occ", u), oo[u], sz);
      chk($sformatf("u%0d stall_cnt", u), os[u], exp_cnt[u]);
      fin[u]  = iv[u] && er[u];
      fout[u] = (sz > 0) && ordy[u];
      if (sz > 0 && !ordy[u] && exp_cnt[u] < cnt_max[u]) exp_cnt[u]++;
    end
    @(posedge CLK);
    for (int u = 0; u < 2; u++) begin
      if (fout[u]) qpop(u);
      if (fl[u]) begin
        if (u == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (fin[u]) begin
        qpush(u, {ic[u], idat[u]});
      end
      alive[u] = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic drive(input int u, input bit v, input logic [31:0] d, input bit r, input bit f);
    iv[u]   = v;
    idat[u] = d;
    ic[u]   = d[7:0] ^ 8'h5A;
    ordy[u] = r;
    fl[u]   = f;
  endtask

  task automatic check_reset_values();
    chk("rst out_valid a", a_out_valid, 0);
    chk("rst out_ctrl a", a_out_ctrl, 0);
    chk("rst occ a", a_occ, 0);
    chk("rst in_ready a", a_in_ready, 0);
    chk("rst out_data a", a_out_data, 0);
    chk("rst stall a", a_stall, 0);
    chk("rst out_valid b", b_out_valid, 0);
    chk("rst in_ready b", b_in_ready, 0);
    chk("rst occ b", b_occ, 0);
  endtask

  initial begin
    logic [7:0] r_seq[7];
    tests = 0;
    fails = 0;
    cnt_max[0] = 15;
    cnt_max[1] = 65535;
    model_reset();
    RESET = 1'b0;
    for (int u = 0; u < 2; u++) drive(u, 0, 0, 1, 0);
    #3;
    check_reset_values();
    @(negedge CLK);
    RESET = 1'b1;
    step();

    // streaming with downstream always ready
    drive(0, 1, 32'h11, 1, 0); step();
    drive(0, 1, 32'h22, 1, 0); step();
    drive(0, 1, 32'h33, 1, 0); step();
    drive(0, 0, 32'h0, 1, 0);  step(); step();

    // fill the skid buffer, then release
    drive(0, 1, 32'hA, 0, 0); step();
    drive(0, 1, 32'hB, 0, 0); step();
    drive(0, 0, 32'h0, 0, 0); step();
    chk("full occ", a_occ, 2);
    chk("full data", a_out_data, 32'hA);
    drive(0, 0, 32'h0, 1, 0); step(); step(); step();

    // flush while FULL with a new entry offered
    drive(0, 1, 32'hC1, 0, 0); step();
    drive(0, 1, 32'hC2, 0, 0); step();
    drive(0, 1, 32'hC3, 0, 1); step();
    drive(0, 0, 32'h0, 0, 0);  step();

    // long stall saturates the 4-bit counter
    drive(0, 1, 32'hD0, 0, 0); step();
    drive(0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("stall saturated", a_stall, 15);
    drive(0, 0, 32'h0, 1, 0); step(); step();

    // single-entry stage: ready follows OUT_READY combinationally
    r_seq[0] = 1; r_seq[1] = 0; r_seq[2] = 1; r_seq[3] = 1;
    r_seq[4] = 0; r_seq[5] = 0; r_seq[6] = 1;
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 32'h100 + i, r_seq[i][0], 0);
      step();
    end
    drive(1, 0, 32'h0, 1, 0); step();

    // randomized traffic on both stages
    for (int i = 0; i < 400; i++) begin
      for (int u = 0; u < 2; u++)
        drive(u, $urandom_range(0, 1), $urandom, $urandom_range(0, 9) < 6,
              $urandom_range(0, 15) == 0);
      step();
    end

    // asynchronous reset mid-stream while FULL
    drive(1, 0, 32'h0, 1, 0);
    drive(0, 1, 32'hE1, 0, 0); step();
    drive(0, 1, 32'hE2, 0, 0); step();
    drive(0, 1, 32'hE3, 0, 0); step();
    chk("pre-reset occ", a_occ, 2);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    step();
    for (int i = 0; i < 60; i++) begin
      for (int u = 0; u < 2; u++)
        drive(u, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
